// File: rtl/alu_iter.sv
// Iterative integer ALU: single-step ops plus shift-add MUL and restoring DIVU/REMU behind valid/ready.
// Define ALU_ITER_DIV_EN to build the divider; otherwise DIVU/REMU behave as undefined opcodes.
module alu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned ShW = $clog2(WIDTH);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpSltu = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpSll  = 4'b1000;
  localparam logic [3:0] OpSrl  = 4'b1001;
  localparam logic [3:0] OpSra  = 4'b1010;
  localparam logic [3:0] OpMul  = 4'b1100;
`ifdef ALU_ITER_DIV_EN
  localparam logic [3:0] OpDivu = 4'b1101;
  localparam logic [3:0] OpRemu = 4'b1110;
`endif

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] opa_q, opa_d;  // multiplicand / divisor
  logic [WIDTH-1:0] opb_q, opb_d;  // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] acc_q, acc_d;  // product accumulator / partial remainder
  logic [ShW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] single_res;
  logic [ShW-1:0]   shamt;
  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] mul_sum;

  assign in_ready   = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign out_valid  = (state_q == StDone);
  assign busy       = (state_q == StMul) || (state_q == StDiv);
  assign alu_result = result_q;
  assign zero       = (result_q == '0);

  assign accept    = in_valid && in_ready;
  assign shamt     = inp2[ShW-1:0];
  assign last_iter = (cnt_q == ShW'(WIDTH - 1));
  assign mul_sum   = acc_q + (opb_q[0] ? opa_q : '0);

`ifdef ALU_ITER_DIV_EN
  logic             rem_q, rem_d;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;

  // Partial remainder stays below the divisor, so the trial difference fits WIDTH+1 bits.
  assign div_shift = {acc_q, opb_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opa_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
`endif

  always_comb begin
    single_res = '0;
    case (alu_ctrl)
      OpAnd:   single_res = inp1 & inp2;
      OpOr:    single_res = inp1 | inp2;
      OpAdd:   single_res = inp1 + inp2;
      OpXor:   single_res = inp1 ^ inp2;
      OpSltu:  single_res = {{(WIDTH-1){1'b0}}, (inp1 < inp2)};
      OpSub:   single_res = inp1 - inp2;
      OpSlt:   single_res = {{(WIDTH-1){1'b0}}, ($signed(inp1) < $signed(inp2))};
      OpSll:   single_res = inp1 << shamt;
      OpSrl:   single_res = inp1 >> shamt;
      OpSra:   single_res = $signed(inp1) >>> shamt;
      default: single_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`ifdef ALU_ITER_DIV_EN
    rem_d    = rem_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone && out_ready) state_d = StIdle;
        if (accept) begin
          state_d  = StDone;
          result_d = single_res;
          acc_d    = '0;
          cnt_d    = '0;
          opa_d    = inp1;
          opb_d    = inp2;
          if (alu_ctrl == OpMul) begin
            state_d = StMul;
          end
`ifdef ALU_ITER_DIV_EN
          else if (alu_ctrl == OpDivu || alu_ctrl == OpRemu) begin
            rem_d = (alu_ctrl == OpRemu);
            if (inp2 == '0) begin
              result_d = (alu_ctrl == OpRemu) ? inp1 : '1;
            end else begin
              state_d = StDiv;
              opa_d   = inp2;
              opb_d   = inp1;
            end
          end
`endif
        end
      end
      StMul: begin
        acc_d = mul_sum;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d  = StDone;
          result_d = mul_sum;
        end
      end
`ifdef ALU_ITER_DIV_EN
      StDiv: begin
        acc_d = div_rem;
        opb_d = {opb_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d  = StDone;
          result_d = rem_q ? div_rem : {opb_q[WIDTH-2:0], div_ge};
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`ifdef ALU_ITER_DIV_EN
      rem_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`ifdef ALU_ITER_DIV_EN
      rem_q    <= rem_d;
`endif
    end
  end

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised successor of the single-cycle integer ALU for the pipelined RISC-V core. It keeps the existing opcode encodings and adds XOR/SRA/SLT/SLTU plus iterative multiply and unsigned divide/remainder. Every result is registered behind a valid/ready handshake, so the execute stage can stall on multi-cycle operations. The block sits in EX and feeds the EX/MEM register.

## Interface
- `WIDTH`, default 32: operand/result width. Must be a power of two and at least 8. Shift amount is `inp2[$clog2(WIDTH)-1:0]`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operation presented on `alu_ctrl`/`inp1`/`inp2`.
- `in_ready`  out  1  block can accept an operation this cycle.
- `alu_ctrl`  in  4  opcode, sampled on accept.
- `inp1`, `inp2`  in  WIDTH  operands, sampled on accept.
- `out_valid`  out  1  `alu_result`/`zero` hold a completed result.
- `out_ready`  in  1  consumer takes the result this cycle.
- `alu_result`  out  WIDTH  registered result.
- `zero`  out  1  `alu_result == 0`, decoded from the result register.
- `busy`  out  1  a MUL/DIVU/REMU iteration is in progress.

## Operation
- Opcodes:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SLTU 0101, SUB 0110, SLT 0111 (signed), SLL 1000, SRL 1001, SRA 1010: single-step operations.
  - MUL 1100 returns the low WIDTH bits of the product.
  - DIVU 1101 and REMU 1110: unsigned divide and remainder.
  - Undefined opcodes are single-step and return 0.
- Arithmetic wraps modulo 2^WIDTH. SLT/SLTU return 1 or 0, zero-extended.
- Accept: `in_valid && in_ready` on the rising edge. Operands and opcode are captured into internal registers. Inputs are don't-care at all other times.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → DONE: single-step op accepted; result written in the same edge.
  - IDLE → MUL: MUL accepted; shift-add, one multiplier bit per cycle, WIDTH iterations.
  - IDLE → DIV: DIVU/REMU accepted; restoring divide, one quotient bit per cycle, WIDTH iterations.
  - MUL/DIV → DONE: on the edge completing the final iteration; result written.
  - DONE → IDLE: `out_ready` high and no new accept.
  - DONE → DONE/MUL/DIV: `out_ready && in_valid` in the same cycle (back-to-back accept).
- Handshake signals:
  - `in_ready = (state==IDLE) || (state==DONE && out_ready)`.
  - `out_valid = (state==DONE)`.
  - `busy = (state==MUL || state==DIV)`.
- While `out_valid` is high and `out_ready` is low, `alu_result` and `zero` hold stable.
- Divide by zero: no iteration; goes straight to DONE. DIVU returns all ones, REMU returns `inp1`.
- Reset asserted at any time, including mid-iteration: the operation is aborted and the state returns to IDLE. No result is produced.

## Timing
- Reset values: `out_valid` 0, `busy` 0, `in_ready` 1, `alu_result` 0, `zero` 1.
- Single-step ops: accepted at edge N; `out_valid` high after edge N (latency 1).
- MUL, and DIVU/REMU with nonzero divisor: accepted at edge N; `out_valid` high after edge N+WIDTH (latency WIDTH+1).
- Throughput with `out_ready` held high:
  - single-step ops: one per cycle;
  - MUL/DIV: one per WIDTH+1 cycles.
- No combinational path from `in_valid` or operands to any output. The only combinational path is `out_ready` → `in_ready`.

## Configuration
- `ALU_ITER_DIV_EN` defined: DIVU/REMU are implemented as described and the DIV state exists.
- `ALU_ITER_DIV_EN` undefined: no divider logic is built. DIVU/REMU are treated as undefined opcodes (single-step, result 0).

## Test plan
- Reset, then ADD 5+7 with `out_ready`=1 → `out_valid` one cycle later, result 12, `zero`=0. Then SUB 9-9 → result 0, `zero`=1.
- SRA 0x8000_0000 by 4 → 0xF800_0000. SLT -1,1 → 1. SLTU -1,1 → 0. SLL by 33 → shift by 1 (WIDTH=32).
- MUL 0xFFFF_FFFF×3 → 0xFFFF_FFFD after exactly 33 cycles. `busy` is high for 32 cycles and `in_ready` is low throughout.
- DIVU 100/7 → 14 and REMU 100/7 → 2, each after 33 cycles. DIVU 5/0 → 0xFFFF_FFFF after 1 cycle; REMU 5/0 → 5. With the macro undefined, both return 0 after 1 cycle.
- Back-pressure: hold `out_ready`=0 for 5 cycles after ADD completes → result stable, `in_ready` 0. Release with `in_valid` high → the new op is accepted on the same edge the old result drains.
- Assert `rst_n`=0 at iteration 10 of a MUL → outputs return to reset values asynchronously. After release, a following ADD completes normally.
